peripheral_gpio_irq_apb4: RTL and testbench
===========================================

// Module: peripheral_gpio_irq_apb4
// PURPOSE
// - Parametrised APB4 GPIO slave: per-pin direction, push-pull/open-drain mode, synchronised input, per-pin interrupts.
// - Interrupt triggers are level or edge per pin, with sticky write-1-to-clear status and a masked, registered irq_o.
// - Sits behind peripheral_apb42ahb3 on the MPSoC peripheral bus; drop-in successor of peripheral_gpio_apb4.
// PARAMETERS
// - PADDR_SIZE  10  APB address width; register index = PADDR[5:2] (word-aligned), upper bits ignored
// - PDATA_SIZE  8   APB data width = pin count; multiple of 8
// - SYNC_DEPTH  3   input synchroniser flops, >=2
// - DEBOUNCE_CYCLES 16  stable cycles required by the debounce filter (GPIO_DEBOUNCE_EN only), >=2
// PORTS
// - PCLK     in   1              clock
// - PRESETn  in   1              reset, asynchronous, active-low
// - PSEL     in   1              APB select
// - PENABLE  in   1              APB access phase
// - PWRITE   in   1              1=write
// - PSTRB    in   PDATA_SIZE/8   byte-lane write strobes
// - PADDR    in   PADDR_SIZE     address
// - PWDATA   in   PDATA_SIZE     write data
// - PRDATA   out  PDATA_SIZE     read data
// - PREADY   out  1              always 1 (zero wait states)
// - PSLVERR  out  1              1 during access phase to unmapped index
// - irq_o    out  1              registered |(TR_STAT & IRQ_ENA)
// - gpio_i   in   PDATA_SIZE     pad inputs (asynchronous)
// - gpio_o   out  PDATA_SIZE     pad output values
// - gpio_oe  out  PDATA_SIZE     pad output enables, 1=drive
// BEHAVIOUR
// - Registers (idx): 0 MODE (1=open-drain), 1 DIRECTION (1=out), 2 OUTPUT, 3 INPUT (RO), 4 TR_TYPE (0=level,1=edge),
//   5 TR_LVL0, 6 TR_LVL1, 7 TR_STAT (W1C), 8 IRQ_ENA; idx 9..15 unmapped. All writable regs reset to 0.
// - Write: on PCLK edge with PSEL&PENABLE&PWRITE, byte lanes with PSTRB=1 update; writes to INPUT ignored, PSLVERR=0.
// - Read: PRDATA combinational from selected reg when PSEL; 0 for unmapped idx or PSEL=0. Unmapped write: no effect, PSLVERR=1.
// - Pads: push-pull gpio_o=OUTPUT, gpio_oe=DIRECTION; open-drain gpio_o=0, gpio_oe=DIRECTION&~OUTPUT. Driven directly from regs.
// - Input path: gpio_i -> SYNC_DEPTH flop chain (reset 0) -> [filter] -> in_q; INPUT reads in_q; prev_q = in_q delayed 1 cycle.
// - Trigger per pin: level: (LVL0&~in_q)|(LVL1&in_q); edge: (LVL0&prev_q&~in_q)|(LVL1&~prev_q&in_q); LVL0&LVL1 edge = any edge.
// - TR_STAT bit sets on trigger, clears on W1C; simultaneous trigger and W1C on same bit -> stays 1 (set wins).
//   Level trigger re-sets status every cycle while condition holds. Status sets regardless of IRQ_ENA.
// - Latency (no filter): pad change sampled at edge 1 -> in_q at edge SYNC_DEPTH -> TR_STAT at SYNC_DEPTH+1 -> irq_o at SYNC_DEPTH+2.
// - Changing TR_TYPE/LVL does not clear TR_STAT; software clears it explicitly.
// - Reset mid-operation: all regs, sync chain, prev_q, filter counters, irq_o -> 0 immediately; no spurious edge after release
//   (prev_q and in_q both 0, so a pad held high yields one rising edge SYNC_DEPTH cycles after release: required behaviour).
// - Reset outputs: PRDATA=0, PREADY=1, PSLVERR=0, irq_o=0, gpio_o=0, gpio_oe=0.
// CONFIGURATION
// - GPIO_DEBOUNCE_EN defined: per-pin counter; in_q takes synchroniser value only after it differs from in_q for DEBOUNCE_CYCLES
//   consecutive cycles; glitches shorter than that never reach INPUT/TR_STAT; counter resets on any return to in_q value.
//   Adds DEBOUNCE_CYCLES cycles to every latency above.
// - GPIO_DEBOUNCE_EN undefined: in_q = synchroniser output; DEBOUNCE_CYCLES unused.
// TESTING
// - Write DIRECTION=0xFF, OUTPUT=0xA5, MODE=0 -> gpio_oe=0xFF, gpio_o=0xA5; MODE=0x0F -> gpio_o=0xA0, gpio_oe=0xFA.
// - gpio_i 0x00->0x3C, read INPUT -> 0x3C no earlier than SYNC_DEPTH cycles after change; PSLVERR=0, PREADY=1 throughout.
// - TR_TYPE=0x01, TR_LVL1=0x01, IRQ_ENA=0x01, pin0 rises -> TR_STAT=0x01 at SYNC_DEPTH+1, irq_o=1 at SYNC_DEPTH+2;
//   W1C 0x01 -> TR_STAT=0x00, irq_o=0 next cycle; W1C coincident with new edge -> TR_STAT stays 0x01.
// - Level low on pin7 (TR_LVL0=0x80, TR_TYPE=0), pin7 held 0 -> W1C has no lasting effect; IRQ_ENA=0 -> irq_o=0, TR_STAT=0x80.
// - Access idx 12: write 0x55 -> PSLVERR=1, no register changes; read -> PRDATA=0x00, PSLVERR=1.
// - GPIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=16: 10-cycle pulse on pin2 -> INPUT, TR_STAT unchanged; 20-cycle pulse -> bit 2 set.

Source files
------------

// File: rtl/peripheral_gpio_irq_apb4.sv
// APB4 GPIO slave: per-pin direction, push-pull/open-drain pads, synchronised inputs, level/edge interrupts.
// Optional input debounce filter enabled by defining GPIO_DEBOUNCE_EN.
module peripheral_gpio_irq_apb4 #(
  parameter int PADDR_SIZE      = 10,
  parameter int PDATA_SIZE      = 8,
  parameter int SYNC_DEPTH      = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [PDATA_SIZE/8-1:0] PSTRB,
  input  logic [PADDR_SIZE-1:0]   PADDR,
  input  logic [PDATA_SIZE-1:0]   PWDATA,
  output logic [PDATA_SIZE-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic                    irq_o,
  input  logic [PDATA_SIZE-1:0]   gpio_i,
  output logic [PDATA_SIZE-1:0]   gpio_o,
  output logic [PDATA_SIZE-1:0]   gpio_oe
);

  localparam int NLANE = PDATA_SIZE / 8;

  localparam logic [3:0] IDX_MODE    = 4'd0;
  localparam logic [3:0] IDX_DIR     = 4'd1;
  localparam logic [3:0] IDX_OUT     = 4'd2;
  localparam logic [3:0] IDX_IN      = 4'd3;
  localparam logic [3:0] IDX_TR_TYPE = 4'd4;
  localparam logic [3:0] IDX_TR_LVL0 = 4'd5;
  localparam logic [3:0] IDX_TR_LVL1 = 4'd6;
  localparam logic [3:0] IDX_TR_STAT = 4'd7;
  localparam logic [3:0] IDX_IRQ_ENA = 4'd8;

  logic [3:0]            idx;
  logic                  mapped;
  logic                  wr_en;
  logic [PDATA_SIZE-1:0] wmask;
  logic                  unused_paddr;

  assign idx          = PADDR[5:2];
  assign mapped       = (idx <= IDX_IRQ_ENA);
  assign wr_en        = PSEL & PENABLE & PWRITE & mapped;
  assign unused_paddr = ^{PADDR[PADDR_SIZE-1:6], PADDR[1:0]};

  always_comb begin
    wmask = '0;
    for (int b = 0; b < NLANE; b++) begin
      wmask[b*8 +: 8] = {8{PSTRB[b]}};
    end
  end

  logic [PDATA_SIZE-1:0] mode_q, mode_d;
  logic [PDATA_SIZE-1:0] dir_q, dir_d;
  logic [PDATA_SIZE-1:0] out_q, out_d;
  logic [PDATA_SIZE-1:0] tr_type_q, tr_type_d;
  logic [PDATA_SIZE-1:0] tr_lvl0_q, tr_lvl0_d;
  logic [PDATA_SIZE-1:0] tr_lvl1_q, tr_lvl1_d;
  logic [PDATA_SIZE-1:0] tr_stat_q, tr_stat_d;
  logic [PDATA_SIZE-1:0] irq_ena_q, irq_ena_d;
  logic [PDATA_SIZE-1:0] stat_clr;
  logic [PDATA_SIZE-1:0] trig;
  logic                  irq_q, irq_d;

  // Input path: synchroniser chain, optional filter, then one-cycle history for edge detection
  logic [SYNC_DEPTH-1:0][PDATA_SIZE-1:0] sync_q, sync_d;
  logic [PDATA_SIZE-1:0]                 sync_out;
  logic [PDATA_SIZE-1:0]                 in_q;
  logic [PDATA_SIZE-1:0]                 prev_q, prev_d;

  assign sync_d   = {sync_q[SYNC_DEPTH-2:0], gpio_i};
  assign sync_out = sync_q[SYNC_DEPTH-1];
  assign prev_d   = in_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [PDATA_SIZE-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [PDATA_SIZE-1:0]            in_d;

  // A pin only follows the synchroniser after disagreeing for DEBOUNCE_CYCLES consecutive cycles
  always_comb begin
    cnt_d = '0;
    in_d  = in_q;
    for (int i = 0; i < PDATA_SIZE; i++) begin
      if (sync_out[i] != in_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          in_d[i] = sync_out[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q <= '0;
      in_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      in_q  <= in_d;
    end
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign in_q = sync_out;
`endif

  always_comb begin
    for (int i = 0; i < PDATA_SIZE; i++) begin
      if (tr_type_q[i]) begin
        trig[i] = (tr_lvl0_q[i] & prev_q[i] & ~in_q[i]) | (tr_lvl1_q[i] & ~prev_q[i] & in_q[i]);
      end else begin
        trig[i] = (tr_lvl0_q[i] & ~in_q[i]) | (tr_lvl1_q[i] & in_q[i]);
      end
    end
  end

  always_comb begin
    mode_d    = mode_q;
    dir_d     = dir_q;
    out_d     = out_q;
    tr_type_d = tr_type_q;
    tr_lvl0_d = tr_lvl0_q;
    tr_lvl1_d = tr_lvl1_q;
    irq_ena_d = irq_ena_q;
    stat_clr  = '0;
    if (wr_en) begin
      case (idx)
        IDX_MODE:    mode_d    = (mode_q    & ~wmask) | (PWDATA & wmask);
        IDX_DIR:     dir_d     = (dir_q     & ~wmask) | (PWDATA & wmask);
        IDX_OUT:     out_d     = (out_q     & ~wmask) | (PWDATA & wmask);
        IDX_TR_TYPE: tr_type_d = (tr_type_q & ~wmask) | (PWDATA & wmask);
        IDX_TR_LVL0: tr_lvl0_d = (tr_lvl0_q & ~wmask) | (PWDATA & wmask);
        IDX_TR_LVL1: tr_lvl1_d = (tr_lvl1_q & ~wmask) | (PWDATA & wmask);
        IDX_TR_STAT: stat_clr  = PWDATA & wmask;
        IDX_IRQ_ENA: irq_ena_d = (irq_ena_q & ~wmask) | (PWDATA & wmask);
        default: ;
      endcase
    end
    // Applying the set after the clear lets a coincident trigger win over W1C
    tr_stat_d = (tr_stat_q & ~stat_clr) | trig;
    irq_d     = |(tr_stat_q & irq_ena_q);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      mode_q    <= '0;
      dir_q     <= '0;
      out_q     <= '0;
      tr_type_q <= '0;
      tr_lvl0_q <= '0;
      tr_lvl1_q <= '0;
      tr_stat_q <= '0;
      irq_ena_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      out_q     <= out_d;
      tr_type_q <= tr_type_d;
      tr_lvl0_q <= tr_lvl0_d;
      tr_lvl1_q <= tr_lvl1_d;
      tr_stat_q <= tr_stat_d;
      irq_ena_q <= irq_ena_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL) begin
      case (idx)
        IDX_MODE:    PRDATA = mode_q;
        IDX_DIR:     PRDATA = dir_q;
        IDX_OUT:     PRDATA = out_q;
        IDX_IN:      PRDATA = in_q;
        IDX_TR_TYPE: PRDATA = tr_type_q;
        IDX_TR_LVL0: PRDATA = tr_lvl0_q;
        IDX_TR_LVL1: PRDATA = tr_lvl1_q;
        IDX_TR_STAT: PRDATA = tr_stat_q;
        IDX_IRQ_ENA: PRDATA = irq_ena_q;
        default:     PRDATA = '0;
      endcase
    end
  end

  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL & PENABLE & ~mapped;
  assign irq_o   = irq_q;

  // Open-drain pins never drive high: they release the pad instead
  assign gpio_o  = out_q & ~mode_q;
  assign gpio_oe = dir_q & ~(mode_q & out_q);

endmodule

// File: tb/tb_peripheral_gpio_irq_apb4.sv
// Self-checking bench for peripheral_gpio_irq_apb4: vector table for register/pad behaviour plus
// hand-written sequences for synchroniser latency, interrupt status W1C races, level triggers and reset.
module tb_peripheral_gpio_irq_apb4;

  localparam int SD = 3;
`ifdef GPIO_DEBOUNCE_EN
  localparam int FLT = 16;
`else
  localparam int FLT = 0;
`endif
  localparam int LAT = SD + FLT;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       PSEL = 1'b0;
  logic       PENABLE = 1'b0;
  logic       PWRITE = 1'b0;
  logic [0:0] PSTRB = 1'b1;
  logic [9:0] PADDR = '0;
  logic [7:0] PWDATA = '0;
  logic [7:0] gpio_i = '0;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;
  logic       irq_o;
  logic [7:0] gpio_o;
  logic [7:0] gpio_oe;

  peripheral_gpio_irq_apb4 #(
    .PADDR_SIZE(10), .PDATA_SIZE(8), .SYNC_DEPTH(SD), .DEBOUNCE_CYCLES(16)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PSTRB(PSTRB), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .irq_o(irq_o), .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe)
  );

  always #5 PCLK = ~PCLK;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    bit         wr;
    logic [3:0] idx;
    logic [7:0] data;
    logic       strb;
    logic [7:0] exp_rd;
    bit         exp_err;
    bit         chk_pad;
    logic [7:0] exp_o;
    logic [7:0] exp_oe;
  } vec_t;
  vec_t vecs[$];

  task automatic sb_push(input string name, input logic [7:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [7:0] act);
    sb_t e;
    n_total++;
    if (sb_q.size() == 0) begin
      $display("FAIL scoreboard_empty: got 0x%02h with no expected entry", act);
    end else begin
      e = sb_q.pop_front();
      if (act === e.exp) n_pass++;
      else $display("FAIL %s: got 0x%02h, expected 0x%02h", e.name, act, e.exp);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    sb_push(name, exp);
    sb_check(act);
  endtask

  task automatic xfer(input bit wr, input logic [3:0] idx, input logic [7:0] data, input logic strb,
                      input bit chk_rd, input logic [7:0] exp_rd, input bit exp_err, input string tag);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
    PADDR = {4'b1010, idx, 2'b00}; PWDATA = data; PSTRB = strb;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    if (chk_rd) sb_push({tag, " prdata"}, exp_rd);
    sb_push({tag, " pslverr"}, {7'b0, exp_err});
    sb_push({tag, " pready"}, 8'h01);
    #1;
    if (chk_rd) sb_check(PRDATA);
    sb_check({7'b0, PSLVERR});
    sb_check({7'b0, PREADY});
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [3:0] idx, input logic [7:0] data, input string tag);
    xfer(1'b1, idx, data, 1'b1, 1'b0, 8'h00, 1'b0, tag);
  endtask

  task automatic rd(input logic [3:0] idx, input logic [7:0] exp, input string tag);
    xfer(1'b0, idx, 8'h00, 1'b1, 1'b1, exp, 1'b0, tag);
  endtask

  task automatic hold_read(input logic [3:0] idx);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = {4'b1010, idx, 2'b00};
  endtask

  function automatic vec_t mk(bit w, logic [3:0] idx, logic [7:0] data, logic strb, logic [7:0] exp_rd,
                              bit exp_err, bit chk_pad, logic [7:0] exp_o, logic [7:0] exp_oe);
    vec_t v;
    v.wr = w; v.idx = idx; v.data = data; v.strb = strb; v.exp_rd = exp_rd;
    v.exp_err = exp_err; v.chk_pad = chk_pad; v.exp_o = exp_o; v.exp_oe = exp_oe;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Register/pad table, applied with gpio_i held at 0
    vecs.push_back(mk(0, 4'd0,  8'h00, 1, 8'h00, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 4'd1,  8'h00, 1, 8'h00, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 4'd2,  8'h00, 1, 8'h00, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 4'd3,  8'h00, 1, 8'h00, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 4'd7,  8'h00, 1, 8'h00, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 4'd8,  8'h00, 1, 8'h00, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(1, 4'd1,  8'hFF, 1, 8'h00, 0, 1, 8'h00, 8'hFF));
    vecs.push_back(mk(1, 4'd2,  8'hA5, 1, 8'h00, 0, 1, 8'hA5, 8'hFF));
    vecs.push_back(mk(1, 4'd0,  8'h00, 1, 8'h00, 0, 1, 8'hA5, 8'hFF));
    vecs.push_back(mk(1, 4'd0,  8'h0F, 1, 8'h00, 0, 1, 8'hA0, 8'hFA));
    vecs.push_back(mk(0, 4'd0,  8'h00, 1, 8'h0F, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(1, 4'd3,  8'h77, 1, 8'h00, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 4'd3,  8'h00, 1, 8'h00, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(1, 4'd2,  8'h00, 0, 8'h00, 0, 1, 8'hA0, 8'hFA));
    vecs.push_back(mk(0, 4'd2,  8'h00, 1, 8'hA5, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(1, 4'd12, 8'h55, 1, 8'h00, 1, 1, 8'hA0, 8'hFA));
    vecs.push_back(mk(0, 4'd4,  8'h00, 1, 8'h00, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 4'd0,  8'h00, 1, 8'h0F, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 4'd12, 8'h00, 1, 8'h00, 1, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 4'd9,  8'h00, 1, 8'h00, 1, 0, 8'h00, 8'h00));
    vecs.push_back(mk(1, 4'd0,  8'h00, 1, 8'h00, 0, 1, 8'hA5, 8'hFF));

    // Reset values
    #2;
    chk("rst prdata", PRDATA, 8'h00);
    chk("rst pready", {7'b0, PREADY}, 8'h01);
    chk("rst pslverr", {7'b0, PSLVERR}, 8'h00);
    chk("rst irq_o", {7'b0, irq_o}, 8'h00);
    chk("rst gpio_o", gpio_o, 8'h00);
    chk("rst gpio_oe", gpio_oe, 8'h00);
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      xfer(vecs[i].wr, vecs[i].idx, vecs[i].data, vecs[i].strb, !vecs[i].wr,
           vecs[i].exp_rd, vecs[i].exp_err, $sformatf("vec%0d", i));
      if (vecs[i].chk_pad) begin
        chk($sformatf("vec%0d gpio_o", i), gpio_o, vecs[i].exp_o);
        chk($sformatf("vec%0d gpio_oe", i), gpio_oe, vecs[i].exp_oe);
      end
    end

    // Synchroniser latency: INPUT must not show the new value before LAT edges
    @(posedge PCLK); #1;
    hold_read(4'd3);
    gpio_i = 8'h3C;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge PCLK); #1;
      if (k == LAT - 1) chk("input early", PRDATA, 8'h00);
      if (k == LAT) begin
        chk("input synced", PRDATA, 8'h3C);
        chk("input pslverr", {7'b0, PSLVERR}, 8'h00);
        chk("input pready", {7'b0, PREADY}, 8'h01);
      end
    end
    PSEL = 1'b0;

    // Rising-edge interrupt on pin 0
    wr(4'd4, 8'h01, "tr_type");
    wr(4'd6, 8'h01, "tr_lvl1");
    wr(4'd8, 8'h01, "irq_ena");
    @(posedge PCLK); #1;
    hold_read(4'd7);
    gpio_i = 8'h3D;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(posedge PCLK); #1;
      if (k == LAT) chk("edge stat early", PRDATA, 8'h00);
      if (k == LAT + 1) begin
        chk("edge stat set", PRDATA, 8'h01);
        chk("edge irq early", {7'b0, irq_o}, 8'h00);
      end
      if (k == LAT + 2) chk("edge irq set", {7'b0, irq_o}, 8'h01);
    end
    PSEL = 1'b0;

    wr(4'd7, 8'h01, "w1c");
    chk("w1c irq lag", {7'b0, irq_o}, 8'h01);
    @(posedge PCLK); #1;
    chk("w1c irq clear", {7'b0, irq_o}, 8'h00);
    rd(4'd7, 8'h00, "w1c stat");

    // W1C landing on the same edge as a new trigger: set wins
    gpio_i = 8'h3C;
    repeat (LAT + 3) @(posedge PCLK);
    #1 gpio_i = 8'h3D;
    repeat (LAT - 2) @(posedge PCLK);
    #1;
    wr(4'd7, 8'h01, "race w1c");
    rd(4'd7, 8'h01, "race stat");

    // Level-low trigger on pin 7 with interrupts masked
    wr(4'd8, 8'h00, "mask");
    wr(4'd7, 8'hFF, "clear all");
    rd(4'd7, 8'h00, "stat cleared");
    wr(4'd5, 8'h80, "tr_lvl0");
    rd(4'd7, 8'h80, "level stat");
    wr(4'd7, 8'h80, "level w1c");
    rd(4'd7, 8'h80, "level resets");
    chk("level masked irq", {7'b0, irq_o}, 8'h00);
    wr(4'd8, 8'h80, "unmask");
    @(posedge PCLK); #1;
    chk("level irq", {7'b0, irq_o}, 8'h01);

`ifdef GPIO_DEBOUNCE_EN
    wr(4'd8, 8'h00, "db mask");
    wr(4'd5, 8'h00, "db lvl0");
    wr(4'd4, 8'h04, "db type");
    wr(4'd6, 8'h04, "db lvl1");
    gpio_i = 8'h00;
    repeat (LAT + 5) @(posedge PCLK);
    #1;
    wr(4'd7, 8'hFF, "db clear");
    gpio_i = 8'h04;
    repeat (10) @(posedge PCLK);
    #1 gpio_i = 8'h00;
    repeat (LAT + 5) @(posedge PCLK);
    rd(4'd3, 8'h00, "db short input");
    rd(4'd7, 8'h00, "db short stat");
    gpio_i = 8'h04;
    repeat (20) @(posedge PCLK);
    #1 gpio_i = 8'h00;
    repeat (4) @(posedge PCLK);
    rd(4'd7, 8'h04, "db long stat");
`endif

    // Asynchronous reset mid-cycle clears outputs immediately
    #3 PRESETn = 1'b0;
    #1;
    chk("midrst irq_o", {7'b0, irq_o}, 8'h00);
    chk("midrst gpio_o", gpio_o, 8'h00);
    chk("midrst gpio_oe", gpio_oe, 8'h00);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    rd(4'd1, 8'h00, "postrst dir");
    rd(4'd7, 8'h00, "postrst stat");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
